rr_decode_arbiter: RTL and testbench

Round-robin arbiter that shares one resource between four requesters. It issues a registered 2-bit address plus an enable that drive a 2-to-4 enable decoder, so exactly one requester sees a grant line at a time. The owner keeps the grant until it drops its request or, if others are waiting, until a hold limit expires. The block is the sequencing front end for any decoder-selected shared resource in the design.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_decode_arbiter_gnt_decode.sv | 13 +
 rtl/rr_decode_arbiter.sv | 117 +++++++++++
 tb/tb_rr_decode_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin pick helper for rr_decode_arbiter.
package arb_pkg;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 2;
    // Hold counter wide enough for the largest legal MAX_HOLD (255).
    localparam int HOLD_W = 8;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // First requester with req high, searching last+1, last+2, last+3, last (mod NREQ).
    function automatic logic [ADDR_W-1:0] rr_pick(input logic [NREQ-1:0]   req,
                                                  input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] idx;
        logic              found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + ADDR_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/rr_decode_arbiter_gnt_decode.sv
// 2-to-4 enable decoder: one-hot grant lines from the registered owner index.
import arb_pkg::*;

module gnt_decode (
    input  logic [ADDR_W-1:0] address,
    input  logic              enable,
    output logic [NREQ-1:0]   gnt
);
    // One decode term per requester line; all lines low when enable is low.
    for (genvar i = 0; i < NREQ; i++) begin : g_dec
        assign gnt[i] = enable && (address == ADDR_W'(i));
    end
endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for four requesters driving a shared 2-to-4 enable decoder.
// Owner keeps the grant until it drops req, or until MAX_HOLD cycles elapse while
// another requester waits. Every handoff passes through one IDLE cycle.
// Optional ARB_STATS_EN adds saturating grant/preempt counters.
import arb_pkg::*;

module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    output logic [ADDR_W-1:0] address,
    output logic              enable,
    output logic [NREQ-1:0]   gnt,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       grant_total,
    output logic [7:0]        preempt_total
`endif
);
    arb_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_last, w_last_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [ADDR_W-1:0] w_winner;
    logic              w_hold_max;
    logic              w_others;
    logic              w_grant_evt;
    logic              w_preempt_evt;

    assign w_winner   = rr_pick(req, r_last);
    assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD - 1));
    assign w_others   = |(req & ~(NREQ'(1) << r_addr));

    // Next-state: arbitrate in IDLE; release beats preempt when both apply.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_grant_evt   = 1'b0;
        w_preempt_evt = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_state_nxt = ARB_GRANT;
                    w_addr_nxt  = w_winner;
                    w_last_nxt  = w_winner;
                    w_hold_nxt  = '0;
                    w_grant_evt = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!req[r_addr]) begin
                    w_state_nxt = ARB_IDLE;
                end else if (w_hold_max && w_others) begin
                    w_state_nxt   = ARB_IDLE;
                    w_preempt_evt = 1'b1;
                end else if (!w_hold_max) begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // State, owner index, round-robin pointer and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_addr  <= '0;
            r_last  <= ADDR_W'(NREQ - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign address = r_addr;
    assign enable  = (r_state == ARB_GRANT);
    assign busy    = enable;

    gnt_decode u_dec (
        .address (r_addr),
        .enable  (enable),
        .gnt     (gnt)
    );

`ifdef ARB_STATS_EN
    logic [15:0] r_grant_total;
    logic [7:0]  r_preempt_total;

    // Saturating event counters for status reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_total   <= '0;
            r_preempt_total <= '0;
        end else begin
            if (w_grant_evt && r_grant_total != 16'hFFFF)
                r_grant_total <= r_grant_total + 16'd1;
            if (w_preempt_evt && r_preempt_total != 8'hFF)
                r_preempt_total <= r_preempt_total + 8'd1;
        end
    end

    assign grant_total   = r_grant_total;
    assign preempt_total = r_preempt_total;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_grant_evt ^ w_preempt_evt;
`endif
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (MAX_HOLD=8).
`timescale 1ns/1ps
module tb_rr_decode_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] address;
    logic       enable;
    logic [3:0] gnt;
    logic       busy;
`ifdef ARB_STATS_EN
    logic [15:0] grant_total;
    logic [7:0]  preempt_total;
`endif
    int total = 0;
    int bad   = 0;

    rr_decode_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .address (address),
        .enable  (enable),
        .gnt     (gnt),
        .busy    (busy)
`ifdef ARB_STATS_EN
        ,
        .grant_total   (grant_total),
        .preempt_total (preempt_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing on a falling edge (safe to sample and drive).
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_stats(input string tag, input int g, input int p);
`ifdef ARB_STATS_EN
        chk({tag, "_grant_total"}, 32'(grant_total), 32'(g));
        chk({tag, "_preempt_total"}, 32'(preempt_total), 32'(p));
`endif
    endtask

    initial begin
        logic [3:0] oh;
        int owners [5] = '{0, 1, 2, 3, 0};

        // Reset state
        #12;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_enable", 32'(enable), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_address", 32'(address), 32'h0);
        chk_stats("rst", 0, 0);
        step(1);
        rst_n = 1'b1;

        // Single request: one-cycle grant, one-cycle release
        req = 4'b0001;
        step(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_address", 32'(address), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step(1);
        chk("t1_rel_gnt", 32'(gnt), 32'h0);
        chk("t1_rel_busy", 32'(busy), 32'h0);

        // All requesting: rotation 0,1,2,3,0 with 8-cycle holds and one idle gap
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            oh = 4'b0001 << owners[o];
            for (int c = 0; c < 8; c++) begin
                step(1);
                chk($sformatf("t2_own%0d_c%0d", o, c), 32'(gnt), 32'(oh));
            end
            if (o == 4) req = 4'b0000;
            step(1);
            chk($sformatf("t2_gap%0d", o), 32'(gnt), 32'h0);
            chk_stats($sformatf("t2_gap%0d", o), o + 1, (o < 4) ? o + 1 : 4);
        end

        // Lone owner holds indefinitely, hold counter saturates
        req = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            step(1);
            chk($sformatf("t3_c%0d", c), 32'(gnt), 32'h4);
        end
        chk("t3_hold_sat", 32'(dut.r_hold), 32'h7);
        chk_stats("t3", 6, 4);
        req = 4'b0000;
        step(1);
        chk("t3_rel", 32'(gnt), 32'h0);

        // Owner 3 releases with req 0 pending: wrap to 0 after one idle cycle
        req = 4'b1000;
        step(1);
        chk("t4_own3", 32'(gnt), 32'h8);
        req = 4'b0001;
        step(1);
        chk("t4_gap", 32'(gnt), 32'h0);
        step(1);
        chk("t4_own0", 32'(gnt), 32'h1);
        chk("t4_addr0", 32'(address), 32'h0);
        req = 4'b0000;
        step(1);

        // Asynchronous reset mid-grant
        req = 4'b0100;
        step(1);
        chk("t5_addr2", 32'(address), 32'h2);
        req = 4'b0101;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", 32'(gnt), 32'h0);
        chk("t5_async_enable", 32'(enable), 32'h0);
        chk("t5_async_addr", 32'(address), 32'h0);
        chk_stats("t5_async", 0, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("t5_first_win0", 32'(gnt), 32'h1);

        // Release coincides with hold limit: single drop to IDLE, counted as release
        step(7);
        chk("t6_still_own0", 32'(gnt), 32'h1);
        chk("t6_hold7", 32'(dut.r_hold), 32'h7);
        req = 4'b0100;
        step(1);
        chk("t6_idle", 32'(gnt), 32'h0);
        chk_stats("t6", 1, 0);
        step(1);
        chk("t6_own2", 32'(gnt), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
